// File: rtl/cdb_result_arbiter.sv
// Completion arbiter: per-channel result FIFOs feeding one registered CDB broadcast.
// Round-robin grant among non-empty buffers, with full buffers taking priority.
module cdb_result_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 6,
  parameter int SIDE_W    = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_CH-1:0]           req_valid,
  output logic [NUM_CH-1:0]           req_ready,
  input  logic [NUM_CH*DATA_W-1:0]    req_data,
  input  logic [NUM_CH*TAG_W-1:0]     req_tag,
  input  logic [NUM_CH*SIDE_W-1:0]    req_side,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [SIDE_W-1:0]           cdb_side,
  output logic [$clog2(NUM_CH)-1:0]   cdb_src,
  output logic [NUM_CH-1:0]           pending
);

  localparam int ENT_W = DATA_W + TAG_W + SIDE_W;
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int SRC_W = $clog2(NUM_CH);

  logic [ENT_W-1:0]  head_ent [NUM_CH];
  logic [NUM_CH-1:0] full, nonempty, elig, push, pop;
  logic              grant;
  logic [SRC_W-1:0]  gnt_idx, cand, last_grant_q;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [SIDE_W-1:0] cdb_side_q;
  logic [SRC_W-1:0]  cdb_src_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ENT_W-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Ready comes from registered count only, so a full buffer stays closed even while popped.
    assign full[i]     = (cnt_q == CNT_W'(BUF_DEPTH));
    assign nonempty[i] = (cnt_q != '0);
    assign push[i]     = req_valid[i] & ~full[i] & ~flush;
    assign pop[i]      = grant & (gnt_idx == SRC_W'(i));
    assign head_ent[i] = mem_q[head_q];

    always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (flush) begin
        head_d = '0;
        tail_d = '0;
        cnt_d  = '0;
      end else begin
        if (push[i]) tail_d = (tail_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : tail_q + 1'b1;
        if (pop[i])  head_d = (head_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : head_q + 1'b1;
        if (push[i] && !pop[i])      cnt_d = cnt_q + 1'b1;
        else if (pop[i] && !push[i]) cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else begin
        head_q <= head_d;
        tail_q <= tail_d;
        cnt_q  <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push[i])
        mem_q[tail_q] <= {req_data[i*DATA_W +: DATA_W], req_tag[i*TAG_W +: TAG_W],
                          req_side[i*SIDE_W +: SIDE_W]};
    end
  end

  assign req_ready = ~full;
  assign pending   = nonempty;
  assign elig      = (|full) ? full : nonempty;

  // Rotating search beginning just after the last granted channel.
  always_comb begin
    grant   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = SRC_W'((int'(last_grant_q) + k) % NUM_CH);
      if (!grant && elig[cand]) begin
        grant   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (flush) grant = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_data_q   <= '0;
      cdb_side_q   <= '0;
      cdb_src_q    <= '0;
      last_grant_q <= SRC_W'(NUM_CH - 1);
    end else begin
      cdb_valid_q <= grant;
      if (grant) begin
        {cdb_data_q, cdb_tag_q, cdb_side_q} <= head_ent[gnt_idx];
        cdb_src_q    <= gnt_idx;
        last_grant_q <= gnt_idx;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_side  = cdb_side_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_result_arbiter.sv
// Bench for cdb_result_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cdb_result_arbiter;
  localparam int NUM_CH = 4, DATA_W = 32, TAG_W = 6, SIDE_W = 4, BUF_DEPTH = 2;

  logic                     clk = 1'b0;
  logic                     rst, flush;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready, pending;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic [NUM_CH*TAG_W-1:0]  req_tag;
  logic [NUM_CH*SIDE_W-1:0] req_side;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic [SIDE_W-1:0]        cdb_side;
  logic [1:0]               cdb_src;

  cdb_result_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TAG_W(TAG_W),
                       .SIDE_W(SIDE_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_tag(req_tag), .req_side(req_side),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_side(cdb_side), .cdb_src(cdb_src), .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: one queue per channel, results popped in grant order.
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t;
    logic [SIDE_W-1:0] s;
  } ent_t;

  ent_t       mq [NUM_CH][$];
  int         m_last;
  logic       m_valid;
  ent_t       m_ent;
  logic [1:0] m_src;
  bit         m_rdy [NUM_CH];
  bit         m_any_full;
  int         m_g, m_c;
  logic [NUM_CH-1:0] e_pend, e_rdy;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      m_last  = NUM_CH - 1;
      m_valid = 1'b0;
      m_ent   = '0;
      m_src   = '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      m_valid = 1'b0;
    end else begin
      m_any_full = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_rdy[i] = (mq[i].size() < BUF_DEPTH);
        if (mq[i].size() == BUF_DEPTH) m_any_full = 1'b1;
      end
      m_g = -1;
      for (int k = 1; k <= NUM_CH; k++) begin
        m_c = (m_last + k) % NUM_CH;
        if (m_g < 0 && (m_any_full ? (mq[m_c].size() == BUF_DEPTH) : (mq[m_c].size() > 0)))
          m_g = m_c;
      end
      if (m_g >= 0) begin
        m_ent   = mq[m_g].pop_front();
        m_src   = m_g[1:0];
        m_valid = 1'b1;
        m_last  = m_g;
      end else begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++)
        if (req_valid[i] && m_rdy[i])
          mq[i].push_back({req_data[i*DATA_W +: DATA_W], req_tag[i*TAG_W +: TAG_W],
                           req_side[i*SIDE_W +: SIDE_W]});
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        e_pend[i] = (mq[i].size() != 0);
        e_rdy[i]  = (mq[i].size() != BUF_DEPTH);
      end
      chk("model_cdb_valid", cdb_valid, m_valid);
      chk("model_cdb_tag",   cdb_tag,   m_ent.t);
      chk("model_cdb_data",  cdb_data,  m_ent.d);
      chk("model_cdb_side",  cdb_side,  m_ent.s);
      chk("model_cdb_src",   cdb_src,   m_src);
      chk("model_pending",   pending,   e_pend);
      chk("model_req_ready", req_ready, e_rdy);
    end
  end

  task automatic set_push(int ch, logic [5:0] tag, logic [31:0] data);
    req_valid[ch] = 1'b1;
    req_tag[ch*TAG_W +: TAG_W]    = tag;
    req_data[ch*DATA_W +: DATA_W] = data;
    req_side[ch*SIDE_W +: SIDE_W] = tag[3:0];
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0;
    req_data = '0; req_tag = '0; req_side = '0;
    tick(); tick();
    rst = 1'b0;
    cmp_en = 1'b1;

    chk("reset_valid",   cdb_valid, 0);
    chk("reset_pending", pending,   4'b0000);
    chk("reset_ready",   req_ready, 4'b1111);
    chk("reset_tag",     cdb_tag,   0);
    chk("reset_data",    cdb_data,  0);
    chk("reset_src",     cdb_src,   0);

    // Single result on ch1, broadcast two edges after the push.
    set_push(1, 6'h05, 32'hDEADBEEF);
    tick();
    req_valid = '0;
    chk("single_pending", pending, 4'b0010);
    chk("single_valid_early", cdb_valid, 0);
    tick();
    chk("single_valid", cdb_valid, 1);
    chk("single_tag",   cdb_tag,   6'h05);
    chk("single_data",  cdb_data,  32'hDEADBEEF);
    chk("single_src",   cdb_src,   1);
    tick();
    chk("single_valid_after", cdb_valid, 0);

    // Round-robin across all four channels, two entries each.
    do_reset();
    for (int e = 0; e < 2; e++) begin
      for (int ch = 0; ch < NUM_CH; ch++) set_push(ch, 6'(ch*8 + e), 32'(ch*256 + e));
      tick();
    end
    req_valid = '0;
    for (int n = 0; n < 8; n++) begin
      chk("rr_valid", cdb_valid, 1);
      chk("rr_src",   cdb_src,   n % 4);
      chk("rr_tag",   cdb_tag,   (n % 4) * 8 + n / 4);
      tick();
    end
    chk("rr_valid_end", cdb_valid, 0);

    // Full override: ch3 fills while ch0 streams.
    do_reset();
    set_push(0, 6'h10, 32'h100); set_push(3, 6'h30, 32'h300);
    tick();
    set_push(0, 6'h11, 32'h101); set_push(3, 6'h31, 32'h301);
    tick();
    chk("full_ready3",  req_ready[3], 0);
    chk("full_pending", pending, 4'b1001);
    chk("full_src_a",   cdb_src, 0);
    req_valid[3] = 1'b0;
    set_push(0, 6'h12, 32'h102);
    tick();
    chk("full_valid_b", cdb_valid, 1);
    chk("full_src_b",   cdb_src,   3);
    chk("full_tag_b",   cdb_tag,   6'h30);
    set_push(0, 6'h13, 32'h103);
    tick();
    chk("full_src_c", cdb_src, 0);
    chk("full_tag_c", cdb_tag, 6'h11);
    req_valid = '0;
    repeat (8) tick();

    // Pointer wrap on ch2 with balanced push/pop.
    for (int t = 1; t <= 5; t++) begin
      set_push(2, 6'(t), 32'(t * 100));
      tick();
      chk("wrap_ready2", req_ready[2], 1);
      if (t >= 2) begin
        chk("wrap_tag", cdb_tag, t - 1);
        chk("wrap_src", cdb_src, 2);
      end
    end
    req_valid = '0;
    tick();
    chk("wrap_tag_last", cdb_tag, 5);
    chk("wrap_valid_last", cdb_valid, 1);
    tick();
    chk("wrap_valid_end", cdb_valid, 0);

    // Flush with a concurrent push; last_grant must survive it.
    set_push(1, 6'h21, 32'h201);
    tick();
    set_push(1, 6'h22, 32'h202); set_push(2, 6'h23, 32'h203); set_push(3, 6'h24, 32'h204);
    tick();
    chk("flush_pre_valid", cdb_valid, 1);
    chk("flush_pre_src",   cdb_src,   1);
    req_valid = '0;
    flush = 1'b1;
    set_push(0, 6'h25, 32'h205);
    tick();
    flush = 1'b0;
    req_valid = '0;
    chk("flush_valid",   cdb_valid, 0);
    chk("flush_pending", pending,   4'b0000);
    chk("flush_ready",   req_ready, 4'b1111);
    set_push(0, 6'h26, 32'h206); set_push(2, 6'h27, 32'h207);
    tick();
    req_valid = '0;
    chk("flush_post_pending", pending, 4'b0101);
    tick();
    chk("flush_post_src_a", cdb_src, 2);
    chk("flush_post_tag_a", cdb_tag, 6'h27);
    tick();
    chk("flush_post_src_b", cdb_src, 0);
    chk("flush_post_tag_b", cdb_tag, 6'h26);
    tick();
    chk("flush_post_valid", cdb_valid, 0);

    // Reset mid-stream.
    for (int e = 0; e < 2; e++) begin
      for (int ch = 0; ch < NUM_CH; ch++) set_push(ch, 6'(6'h30 + ch + 4*e), 32'(ch + 16*e));
      tick();
    end
    chk("mid_pre_valid", cdb_valid, 1);
    chk("mid_pre_src",   cdb_src,   1);
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valid",   cdb_valid, 0);
    chk("mid_pending", pending,   4'b0000);
    chk("mid_ready",   req_ready, 4'b1111);
    chk("mid_src",     cdb_src,   0);
    set_push(3, 6'h3A, 32'h33); set_push(0, 6'h0A, 32'h11);
    tick();
    req_valid = '0;
    tick();
    chk("mid_first_src", cdb_src, 0);
    chk("mid_first_tag", cdb_tag, 6'h0A);
    tick();
    chk("mid_second_src", cdb_src, 3);
    tick();
    chk("mid_end_valid", cdb_valid, 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_result_arbiter.md
# cdb_result_arbiter

Parametrised completion arbiter between the execution units (ALU, MUL, DIV, AGU and any added later) and the common data bus (CDB). Each unit pushes finished results through a valid/ready handshake into a private result buffer. The arbiter grants one buffer per cycle, using round-robin order with a full-buffer priority override, and drives a registered CDB broadcast. A global flush clears all in-flight results on branch recovery.

## Interface
Parameters:
- NUM_CH, 4: number of execution channels (2..8).
- DATA_W, 32: result width.
- TAG_W, 6: destination tag width.
- SIDE_W, 4: sideband bits per result (branch, branch_taken, jalr, store_pc); passed through untouched.
- BUF_DEPTH, 2: entries per channel buffer; power of 2, 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all buffered results; synchronous.
- req_valid  in  NUM_CH  per-channel result valid.
- req_ready  out  NUM_CH  per-channel buffer can accept.
- req_data  in  NUM_CH*DATA_W  result data; channel i at bits [i*DATA_W +: DATA_W].
- req_tag  in  NUM_CH*TAG_W  destination tag, packed the same way.
- req_side  in  NUM_CH*SIDE_W  sideband, packed the same way.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_data  out  DATA_W  broadcast data.
- cdb_side  out  SIDE_W  broadcast sideband.
- cdb_src  out  $clog2(NUM_CH)  index of the granted channel.
- pending  out  NUM_CH  buffer i is non-empty.

## Operation
- Each channel has a circular FIFO with a head pointer, a tail pointer, and a count of width $clog2(BUF_DEPTH)+1.
- req_ready[i] = (count_i != BUF_DEPTH). This is a function of registered count only. There is no same-cycle pass-through: a full buffer stays not-ready even when it is popped that cycle.
- Push: req_valid[i] & req_ready[i] writes {data, tag, side} at the tail; the tail wraps modulo BUF_DEPTH.
- Pop: the granted channel's head advances (wraps). A push and pop on the same channel in the same cycle leave count unchanged.
- Eligibility: the set E is every channel with a full buffer if at least one is full; otherwise every non-empty channel.
- Arbitration:
  - Search E starting at (last_grant+1) mod NUM_CH, ascending and wrapping. The first hit is the grant.
  - last_grant updates only when a grant occurs.
  - If E is empty, there is no grant.
- CDB register: on a grant, cdb_* load the granted head entry, cdb_src loads the channel index, and cdb_valid=1. With no grant, cdb_valid=0 and the other cdb_* fields hold their previous values.
- Flush, in the cycle it is asserted:
  - All counts and pointers go to 0.
  - Any push that cycle is dropped.
  - No grant occurs, and cdb_valid=0 next cycle.
  - last_grant is kept.
- Precedence: rst over flush; flush over push and pop.

## Timing
- Reset values:
  - req_ready all 1.
  - cdb_valid 0; cdb_tag, cdb_data, cdb_side and cdb_src 0.
  - pending 0.
  - last_grant = NUM_CH-1, so channel 0 is searched first.
- pending[i] = (count_i != 0), from registered state.
- Latency: a result accepted at edge k is visible in pending after edge k. If it is granted in cycle k→k+1, cdb_valid is high after edge k+1. Minimum request-to-broadcast latency is 2 edges.
- Throughput: one broadcast per cycle, sustained while any buffer is non-empty.
- Fairness: with all channels continuously non-empty and none full, grant order is a strict rotation.
- Full override: a full channel is granted within at most NUM_CH-1 cycles of becoming full, even when others are pending.
- Reset asserted mid-operation: all state returns to reset values at that edge, and buffered results are lost.

## Test plan
- Single result: reset, then ch1 pushes tag=0x05, data=0xDEADBEEF for one cycle. Required: cdb_valid=1, tag 0x05, data 0xDEADBEEF, cdb_src=1 exactly 2 edges after the push; cdb_valid=0 the following cycle.
- Round-robin: NUM_CH=4 with all channels preloaded with 2 entries in the same cycle. Required grant order 0,1,2,3,0,1,2,3, with cdb_valid high for 8 consecutive cycles.
- Full priority: BUF_DEPTH=2, ch0 pushes one entry per cycle continuously, ch3 pushes 2 entries back-to-back. Required: once ch3's count is 2, ch3 is granted before any further ch0 grant; req_ready[3]=0 while count is 2.
- Backpressure and wrap: ch2 pushes 5 entries with tags 1..5 while the other channels are idle. Required: tags appear in order 1..5 across pointer wrap, with no duplicates or losses; req_ready[2] never drops because push and pop balance.
- Flush: 3 channels hold entries, then flush is pulsed together with a push on ch0. Required: cdb_valid=0 next cycle, pending=0, the ch0 push is discarded, and the next new push still follows the preserved last_grant order.
- Reset mid-stream: assert rst while buffers are non-empty and cdb_valid=1. Required: next cycle cdb_valid=0, pending=0, req_ready all 1; the first grant after release goes to channel 0.
